shift_sched: RTL
================

SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter DATA_W, default 8: operand and result width in bits.
REQ-002 Parameter AMT_W, default 4: shift-amount width in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 req_op  input  2x2  per-requester opcode: 0 SHL, 1 SHR (logical), 2 SSHR (arithmetic), 3 DYN.
REQ-008 req_data  input  2xDATA_W  per-requester operand.
REQ-009 req_amt  input  2xAMT_W  per-requester shift amount; unsigned for ops 0-2, two's-complement for DYN.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  consumer accept.
REQ-012 rsp_data  output  DATA_W  shift result.
REQ-013 rsp_src  output  1  index of the requester that owns rsp_data.
REQ-014 stall_cnt  output  16  count of response stall cycles (see Configuration).

Function
REQ-015 The block SHALL share one shifter between two requesters and hold at most one result.
REQ-016 The FSM SHALL have two states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-017 req_ready SHALL be nonzero only in IDLE, or in HOLD during a cycle with rsp_ready=1; at most one bit SHALL be high, and that bit SHALL be high only when the matching req_valid bit is high (grant).
REQ-018 Arbitration SHALL be round-robin: a requester that has just been granted has the lowest priority on the next contention; the pointer SHALL change only on a grant.
REQ-019 A request accepted in cycle N SHALL produce rsp_valid=1 in cycle N+1, with registered rsp_data and rsp_src.
REQ-020 In HOLD with rsp_ready=1 and a new grant, the FSM SHALL stay in HOLD with the new result, giving a throughput of one result per cycle.
REQ-021 In HOLD with rsp_ready=1 and no grant, the FSM SHALL go to IDLE; with rsp_ready=0, rsp_data and rsp_src SHALL stay stable.
REQ-022 SHL/SHR SHALL zero-fill; an amount >= DATA_W SHALL give 0.
REQ-023 SSHR SHALL sign-fill; an amount >= DATA_W SHALL give all copies of the operand MSB.
REQ-024 DYN SHALL perform SSHR by amt when amt >= 0, and SHL by |amt| when amt < 0; -2^(AMT_W-1) SHALL be handled as a full-magnitude left shift.
REQ-025 The result SHALL be computed at operand width and then kept at DATA_W, truncating on the left or extending on the right as the op defines.

Reset
REQ-026 While rst_n=0 at a clock edge: state SHALL become IDLE, rsp_valid=0, rsp_data=0, rsp_src=0, the RR pointer SHALL favour requester 0, stall_cnt=0, and req_ready SHALL be 0 that cycle.
REQ-027 Reset asserted while in HOLD SHALL discard the held result with no response.

Configuration
REQ-028 When SHIFT_SCHED_STALL_CNT_EN is defined, stall_cnt SHALL increment, saturating at 0xFFFF, each cycle with rsp_valid=1 and rsp_ready=0.
REQ-029 Without SHIFT_SCHED_STALL_CNT_EN, stall_cnt SHALL remain in the interface and be driven constant 0, with no counter flops.

Structure
REQ-030 Package shift_pkg SHALL hold the opcode enum shift_op_e and the default widths.
REQ-031 The combinational shifter SHALL be sub-module shift_core (op, data, amt -> result); shift_sched SHALL hold only arbitration, FSM, output register and counter.

Verification (DATA_W=8, AMT_W=4)
REQ-032 req0 SHL 0x81 amt 1 -> next cycle rsp_valid=1, rsp_data=0x02, rsp_src=0.
REQ-033 SSHR 0x80 amt 9 -> 0xFF; SHR 0x80 amt 9 -> 0x00; SHL 0x01 amt 15 -> 0x00.
REQ-034 DYN 0x05 amt 4'b1110 -> 0x14; DYN 0xF0 amt 4'b0011 -> 0xFE; DYN 0x01 amt 4'b1000 -> 0x00.
REQ-035 Both req_valid held high from reset, rsp_ready=1 -> grants 0,1,0,1 on consecutive cycles and one response per cycle, with rsp_src alternating.
REQ-036 rsp_ready=0 for 3 cycles while in HOLD -> rsp_data stable, req_ready=0, stall_cnt=3 (with macro) or 0 (without).
REQ-037 rst_n=0 for one cycle while rsp_valid=1 -> rsp_valid=0 after that edge, next grant to requester 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and default widths for the two-requester shift scheduler.
package shift_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_AMT_W  = 4;

    typedef enum logic [1:0] {
        OP_SHL  = 2'd0,
        OP_SHR  = 2'd1,
        OP_SSHR = 2'd2,
        OP_DYN  = 2'd3
    } shift_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: logical/arithmetic shifts plus a signed-amount DYN shift.
module shift_core
    import shift_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  shift_op_e         op,
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] result
);

    // One extra bit so that the most negative amount keeps its full magnitude.
    logic [AMT_W:0] w_mag;

    assign w_mag = {1'b0, ~amt} + (AMT_W+1)'(1);

    always_comb begin
        result = '0;
        unique case (op)
            OP_SHL:  result = data << amt;
            OP_SHR:  result = data >> amt;
            OP_SSHR: result = $signed(data) >>> amt;
            OP_DYN: begin
                if (amt[AMT_W-1]) begin
                    result = data << w_mag;
                end else begin
                    result = $signed(data) >>> amt;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one shift_core between two requesters, one-deep result register.
// Define SHIFT_SCHED_STALL_CNT_EN to build the saturating response-stall counter.
//
// state   | meaning
// IDLE    | no result held, any valid request may be granted
// HOLD    | result held (rsp_valid=1); new grant only when rsp_ready=1
module shift_sched
    import shift_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_op,
    input  logic [2*DATA_W-1:0]   req_data,
    input  logic [2*AMT_W-1:0]    req_amt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_src,
    output logic [15:0]           stall_cnt
);

    sched_state_e        r_state;
    sched_state_e        w_state_nxt;
    logic                r_rr_ptr;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_src;
    logic                w_can_accept;
    logic                w_grant;
    logic                w_grant_idx;
    logic [DATA_W-1:0]   w_result;

    // r_rr_ptr names the requester that wins when both are valid.
    always_comb begin
        w_grant_idx = r_rr_ptr;
        if (req_valid != 2'b11) begin
            w_grant_idx = req_valid[1];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = 1'b0;
        w_grant      = 1'b0;
        req_ready    = 2'b00;
        unique case (r_state)
            ST_IDLE: w_can_accept = 1'b1;
            ST_HOLD: w_can_accept = rsp_ready;
            default: w_can_accept = 1'b0;
        endcase
        w_grant = rst_n && w_can_accept && (req_valid != 2'b00);
        if (w_grant) begin
            req_ready[w_grant_idx] = 1'b1;
            w_state_nxt = ST_HOLD;
        end else if (r_state == ST_HOLD && rsp_ready) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    shift_core #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_core (
        .op     (shift_op_e'(req_op[w_grant_idx*2 +: 2])),
        .data   (req_data[w_grant_idx*DATA_W +: DATA_W]),
        .amt    (req_amt[w_grant_idx*AMT_W +: AMT_W]),
        .result (w_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_src  <= 1'b0;
        end else if (w_grant) begin
            r_rr_ptr   <= ~w_grant_idx;
            r_rsp_data <= w_result;
            r_rsp_src  <= w_grant_idx;
        end
    end

    assign rsp_valid = (r_state == ST_HOLD);
    assign rsp_data  = r_rsp_data;
    assign rsp_src   = r_rsp_src;

`ifdef SHIFT_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (rsp_valid && !rsp_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
